// File: rtl/bidir_bus_pkg.sv
// ============================================================================
// Module   : bidir_bus_pkg
// Brief    : Shared types and constants for the bidirectional bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bidir_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TURN  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Width of a down-to-zero phase counter that must reach max(a,b,c)-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bidir_rr_arb2.sv
// ============================================================================
// Module   : bidir_rr_arb2
// Brief    : Two-way round-robin arbiter; the pointer side wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidir_rr_arb2
    import bidir_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic grant_en,
    output logic gnt_sel,
    output logic gnt_vld
);

    logic r_ptr;

    always_comb begin
        gnt_vld = req_a | req_b;
        if (req_a && req_b) begin
            gnt_sel = r_ptr;
        end else if (req_b) begin
            gnt_sel = SEL_B;
        end else begin
            gnt_sel = SEL_A;
        end
    end

    // Any grant, contended or not, hands priority to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= SEL_A;
        end else if (grant_en && gnt_vld) begin
            r_ptr <= ~gnt_sel;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bidir_bus_arbiter.sv
// ============================================================================
// Module   : bidir_bus_arbiter
// Brief    : Two-requester sequencer for a half-duplex tri-state bus with
//            read-to-write turnaround. Optional write read-back check is
//            enabled by defining BIDIR_BUS_WRCHK_EN (adds wr_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidir_bus_arbiter
    import bidir_bus_pkg::*;
#(
    parameter int DW       = 8,
    parameter int WR_CYC   = 2,
    parameter int RD_CYC   = 2,
    parameter int TURN_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    output logic          bus_wr,
    inout  wire  [DW-1:0] bus_data,
`ifdef BIDIR_BUS_WRCHK_EN
    output logic          wr_err,
`endif
    output logic          busy
);

    localparam int CNT_W = cnt_width(WR_CYC, RD_CYC, TURN_CYC);

    localparam logic [CNT_W-1:0] c_wr_last   = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] c_rd_last   = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] c_turn_last = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    logic             r_sel;
    logic [DW-1:0]    r_wdata;
    logic             r_drv;
    logic             r_turn;
    logic [CNT_W-1:0] r_cnt;

    logic             w_gnt_sel;
    logic             w_gnt_vld;
    logic             w_gnt_we;
    logic [DW-1:0]    w_gnt_wdata;

    bidir_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .grant_en (r_state == IDLE),
        .gnt_sel  (w_gnt_sel),
        .gnt_vld  (w_gnt_vld)
    );

    assign w_gnt_we    = (w_gnt_sel == SEL_B) ? we_b    : we_a;
    assign w_gnt_wdata = (w_gnt_sel == SEL_B) ? wdata_b : wdata_a;

    // r_drv clears on the asynchronous reset, so the bus is released at once.
    assign bus_data = r_drv ? r_wdata : {DW{1'bz}};
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= SEL_A;
            r_wdata <= '0;
            r_drv   <= 1'b0;
            r_turn  <= 1'b0;
            r_cnt   <= '0;
            bus_wr  <= 1'b1;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            rdata_a <= '0;
            rdata_b <= '0;
`ifdef BIDIR_BUS_WRCHK_EN
            wr_err  <= 1'b0;
`endif
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_sel   <= w_gnt_sel;
                        r_wdata <= w_gnt_wdata;
                        r_cnt   <= '0;
                        if (!w_gnt_we) begin
                            r_state <= READ;
                        end else if (r_turn) begin
                            r_state <= TURN;
                        end else begin
                            r_state <= WRITE;
                            r_drv   <= 1'b1;
                            bus_wr  <= 1'b0;
                        end
                    end
                end
                TURN: begin
                    if (r_cnt == c_turn_last) begin
                        r_cnt   <= '0;
                        r_turn  <= 1'b0;
                        r_state <= WRITE;
                        r_drv   <= 1'b1;
                        bus_wr  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                WRITE: begin
                    if (r_cnt == c_wr_last) begin
                        r_cnt   <= '0;
                        r_drv   <= 1'b0;
                        bus_wr  <= 1'b1;
                        r_state <= ACK;
                        if (r_sel == SEL_B) ack_b <= 1'b1;
                        else                ack_a <= 1'b1;
`ifdef BIDIR_BUS_WRCHK_EN
                        if (bus_data != r_wdata) wr_err <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                READ: begin
                    if (r_cnt == c_rd_last) begin
                        r_cnt   <= '0;
                        r_turn  <= 1'b1;
                        r_state <= ACK;
                        if (r_sel == SEL_B) begin
                            rdata_b <= bus_data;
                            ack_b   <= 1'b1;
                        end else begin
                            rdata_a <= bus_data;
                            ack_a   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bidir_bus_arbiter.sv
// ============================================================================
// Module   : tb_bidir_bus_arbiter
// Brief    : Directed self-checking bench for bidir_bus_arbiter; the bench
//            acts as the bus slave, driving slv_val whenever bus_wr is high.
//            Covers the wr_err path when BIDIR_BUS_WRCHK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bidir_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, ack_b;
    logic [7:0] rdata_a, rdata_b;
    logic       bus_wr;
    logic       busy;
    logic [7:0] slv_val;
    wire  [7:0] bus_data;
`ifdef BIDIR_BUS_WRCHK_EN
    logic       wr_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic exp_b;

    always #5 clk = ~clk;

    // Slave side of the half-duplex bus: only drives while the DUT reads/idles.
    assign bus_data = bus_wr ? slv_val : 8'hzz;

    bidir_bus_arbiter #(
        .DW(8), .WR_CYC(2), .RD_CYC(2), .TURN_CYC(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .we_a     (we_a),
        .wdata_a  (wdata_a),
        .ack_a    (ack_a),
        .rdata_a  (rdata_a),
        .req_b    (req_b),
        .we_b     (we_b),
        .wdata_b  (wdata_b),
        .ack_b    (ack_b),
        .rdata_b  (rdata_b),
        .bus_wr   (bus_wr),
        .bus_data (bus_data),
`ifdef BIDIR_BUS_WRCHK_EN
        .wr_err   (wr_err),
`endif
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; wdata_a = 8'h00;
        req_b = 1'b0; we_b = 1'b0; wdata_b = 8'h00;
        slv_val = 8'h00;
        tick();
        tick();

        chk("rst_bus_wr",  32'(bus_wr),   32'h1);
        chk("rst_ack_a",   32'(ack_a),    32'h0);
        chk("rst_ack_b",   32'(ack_b),    32'h0);
        chk("rst_rdata_a", 32'(rdata_a),  32'h00);
        chk("rst_rdata_b", 32'(rdata_b),  32'h00);
        chk("rst_busy",    32'(busy),     32'h0);
        chk("rst_bus",     32'(bus_data), 32'h00);
`ifdef BIDIR_BUS_WRCHK_EN
        chk("rst_wr_err",  32'(wr_err),   32'h0);
`endif
        rst = 1'b0;
        tick();

        // A writes 0xA5 from reset
        req_a = 1'b1; we_a = 1'b1; wdata_a = 8'hA5;
        tick();
        chk("wr1_c1_bus_wr", 32'(bus_wr),   32'h0);
        chk("wr1_c1_data",   32'(bus_data), 32'hA5);
        chk("wr1_c1_busy",   32'(busy),     32'h1);
        tick();
        chk("wr1_c2_bus_wr", 32'(bus_wr),   32'h0);
        chk("wr1_c2_data",   32'(bus_data), 32'hA5);
        chk("wr1_c2_ack_a",  32'(ack_a),    32'h0);
        tick();
        chk("wr1_ack_a",     32'(ack_a),    32'h1);
        chk("wr1_ack_b",     32'(ack_b),    32'h0);
        chk("wr1_ack_bus_wr",32'(bus_wr),   32'h1);
        chk("wr1_ack_bus",   32'(bus_data), 32'h00);
        req_a = 1'b0;
        tick();
        chk("wr1_idle_ack",  32'(ack_a),    32'h0);
        chk("wr1_idle_busy", 32'(busy),     32'h0);

        // B reads 0x3C
        req_b = 1'b1; we_b = 1'b0; slv_val = 8'h3C;
        tick();
        chk("rd_c1_bus_wr",  32'(bus_wr),   32'h1);
        chk("rd_c1_bus",     32'(bus_data), 32'h3C);
        tick();
        chk("rd_c2_ack_b",   32'(ack_b),    32'h0);
        chk("rd_c2_bus",     32'(bus_data), 32'h3C);
        tick();
        chk("rd_ack_b",      32'(ack_b),    32'h1);
        chk("rd_rdata_b",    32'(rdata_b),  32'h3C);
        chk("rd_ack_a",      32'(ack_a),    32'h0);
        req_b = 1'b0; slv_val = 8'h00;
        tick();
        chk("rd_hold_rdata", 32'(rdata_b),  32'h3C);
        chk("rd_idle_ack_b", 32'(ack_b),    32'h0);

        // A read (pointer on A) then B write 0x5A: one TURN cycle before WRITE
        req_a = 1'b1; we_a = 1'b0; slv_val = 8'h11;
        req_b = 1'b1; we_b = 1'b1; wdata_b = 8'h5A;
        tick();
        chk("rw_rd_bus",     32'(bus_data), 32'h11);
        tick();
        tick();
        chk("rw_ack_a",      32'(ack_a),    32'h1);
        chk("rw_ack_b",      32'(ack_b),    32'h0);
        chk("rw_rdata_a",    32'(rdata_a),  32'h11);
        req_a = 1'b0; slv_val = 8'h00;
        tick();
        chk("rw_idle_busy",  32'(busy),     32'h0);
        tick();
        chk("rw_turn_bus_wr",32'(bus_wr),   32'h1);
        chk("rw_turn_bus",   32'(bus_data), 32'h00);
        chk("rw_turn_busy",  32'(busy),     32'h1);
        tick();
        chk("rw_wr_bus_wr",  32'(bus_wr),   32'h0);
        chk("rw_wr_bus",     32'(bus_data), 32'h5A);
        tick();
        tick();
        chk("rw_wr_ack_b",   32'(ack_b),    32'h1);

        // req_b held: write->write with no TURN
        wdata_b = 8'h6B;
        tick();
        tick();
        chk("ww_bus_wr",     32'(bus_wr),   32'h0);
        chk("ww_bus",        32'(bus_data), 32'h6B);
        tick();
        tick();
        chk("ww_ack_b",      32'(ack_b),    32'h1);
        req_b = 1'b0;
        tick();

        // Both writing and held: grants alternate A, B, A, B
        req_a = 1'b1; we_a = 1'b1; wdata_a = 8'hA1;
        req_b = 1'b1; we_b = 1'b1; wdata_b = 8'hB2;
        for (int i = 0; i < 4; i++) begin
            exp_b = (i % 2) == 1;
            tick();
            chk("alt_bus", 32'(bus_data), exp_b ? 32'hB2 : 32'hA1);
            tick();
            tick();
            chk("alt_ack_a", 32'(ack_a), exp_b ? 32'h0 : 32'h1);
            chk("alt_ack_b", 32'(ack_b), exp_b ? 32'h1 : 32'h0);
            if (i == 3) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            tick();
        end

        // Reset during the first WRITE cycle of an A write
        req_a = 1'b1; we_a = 1'b1; wdata_a = 8'h77;
        tick();
        chk("rw1_bus", 32'(bus_data), 32'h77);
        rst = 1'b1;
        #1;
        chk("mid_rst_bus_wr", 32'(bus_wr),   32'h1);
        chk("mid_rst_bus",    32'(bus_data), 32'h00);
        chk("mid_rst_ack_a",  32'(ack_a),    32'h0);
        chk("mid_rst_busy",   32'(busy),     32'h0);
        req_b = 1'b1; we_b = 1'b1; wdata_b = 8'hC3;
        tick();
        chk("in_rst_ack_a",   32'(ack_a),    32'h0);
        rst = 1'b0;
        // Pointer back on A: A wins the tie, then pending B is granted
        tick();
        chk("post_rst_a_bus", 32'(bus_data), 32'h77);
        tick();
        tick();
        chk("post_rst_ack_a", 32'(ack_a),    32'h1);
        chk("post_rst_ack_b0",32'(ack_b),    32'h0);
        req_a = 1'b0;
        tick();
        tick();
        chk("post_rst_b_bus", 32'(bus_data), 32'hC3);
        tick();
        tick();
        chk("post_rst_ack_b", 32'(ack_b),    32'h1);
        req_b = 1'b0;
        tick();
        chk("post_rst_rdata_a", 32'(rdata_a), 32'h00);

`ifdef BIDIR_BUS_WRCHK_EN
        chk("wrchk_clean", 32'(wr_err), 32'h0);
        req_a = 1'b1; we_a = 1'b1; wdata_a = 8'hFF;
        tick();
        force bus_data[0] = 1'b0;
        tick();
        tick();
        release bus_data[0];
        chk("wrchk_ack_a", 32'(ack_a),  32'h1);
        chk("wrchk_err",   32'(wr_err), 32'h1);
        req_a = 1'b0;
        tick();
        tick();
        chk("wrchk_sticky", 32'(wr_err), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrchk_rst", 32'(wr_err), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
